pid: RTL and testbench

Balance-loop PID controller for the self-balancing platform. It converts a 16-bit signed pitch error and pitch rate into a saturated 12-bit signed control effort, `PID_cntrl`, which feeds the downstream motor-math block. It also provides a soft-start timer, `ss_tmr`, that the motor math uses to ramp drive strength after power-up.

---
 rtl/pid_if.sv | 29 ++
 rtl/pid.sv | 118 +++++++++++
 tb/tb_pid.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pid_if.sv
`default_nettype none
// ============================================================================
//  Module      : pid_if
//  Description : Bundle of sample, control and result signals exchanged
//                between the balance-loop PID controller and its driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pid_if;
    logic        vld;        // new pitch sample valid
    logic [15:0] ptch;       // signed pitch error
    logic [15:0] ptch_rt;    // signed pitch rate
    logic        pwr_up;     // soft-start timer enable
    logic        rider_off;  // integrator clear
    logic [11:0] PID_cntrl;  // signed control effort
    logic [7:0]  ss_tmr;     // soft-start timer

    // Driver side: produces samples, observes the controller outputs.
    modport master (
        output vld, ptch, ptch_rt, pwr_up, rider_off,
        input  PID_cntrl, ss_tmr
    );

    // Controller side.
    modport slave (
        input  vld, ptch, ptch_rt, pwr_up, rider_off,
        output PID_cntrl, ss_tmr
    );
endinterface
`default_nettype wire

// File: rtl/pid.sv
`default_nettype none
// ============================================================================
//  Module      : pid
//  Description : Balance-loop PID controller. Saturated P + I + D control
//                effort (combinational from ptch/ptch_rt) and a soft-start
//                timer used by the motor math to ramp drive strength.
//  Revision    : 1.0 - initial release
// ============================================================================
module pid #(
    parameter logic [4:0] P_COEFF  = 5'h09,
    parameter bit         FAST_SIM = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    pid_if.slave      bus
);

    localparam logic [26:0] c_tmr_inc = FAST_SIM ? 27'd256 : 27'd1;

    logic signed [9:0]  w_err_sat;
    logic signed [17:0] w_err_ext;
    logic signed [14:0] w_p_term;
    logic signed [14:0] w_i_term;
    logic signed [15:0] w_rt_shift;
    logic signed [14:0] w_d_term;
    logic signed [15:0] w_sum;
    logic signed [17:0] w_integ_sum;
    logic               w_integ_ovf;
    logic [11:0]        w_pid_cntrl;

    logic signed [17:0] integrator_q, integrator_d;
    logic [26:0]        long_tmr_q, long_tmr_d;

    // Clamp the pitch error into 10-bit signed range.
    always_comb begin
        w_err_sat = bus.ptch[9:0];
        if (!bus.ptch[15] && (bus.ptch[14:9] != 6'h00)) begin
            w_err_sat = 10'sh1FF;
        end else if (bus.ptch[15] && (bus.ptch[14:9] != 6'h3F)) begin
            w_err_sat = 10'sh200;
        end
    end

    assign w_err_ext = {{8{w_err_sat[9]}}, w_err_sat};

    // Largest product is 512*31, which still fits in 15 signed bits.
    assign w_p_term = $signed({{5{w_err_sat[9]}}, w_err_sat}) * $signed({10'd0, P_COEFF});

    // Overflow guard: same-sign addends whose sum flips sign would wrap,
    // so the integrator parks near full scale instead.
    assign w_integ_sum = integrator_q + w_err_ext;
    assign w_integ_ovf = (integrator_q[17] == w_err_ext[17]) &&
                         (w_integ_sum[17] != integrator_q[17]);

    // Integrator next state: rider_off clear beats a valid sample.
    always_comb begin
        integrator_d = integrator_q;
        if (bus.rider_off) begin
            integrator_d = '0;
        end else if (bus.vld && !w_integ_ovf) begin
            integrator_d = w_integ_sum;
        end
    end

    // Integrator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integrator_q <= '0;
        end else begin
            integrator_q <= integrator_d;
        end
    end

    assign w_i_term = {{3{integrator_q[17]}}, integrator_q[17:6]};

    // Arithmetic shift keeps the rate sign; result spans -512..511.
    assign w_rt_shift = $signed(bus.ptch_rt) >>> 6;
    assign w_d_term   = 15'sd0 - $signed(w_rt_shift[14:0]);

    // 16-bit sum of three 15-bit terms cannot overflow internally.
    assign w_sum = {w_p_term[14], w_p_term} + {w_i_term[14], w_i_term} +
                   {w_d_term[14], w_d_term};

    // Saturate the effort to 12-bit signed.
    always_comb begin
        w_pid_cntrl = w_sum[11:0];
        if (!w_sum[15] && (w_sum[14:11] != 4'h0)) begin
            w_pid_cntrl = 12'h7FF;
        end else if (w_sum[15] && (w_sum[14:11] != 4'hF)) begin
            w_pid_cntrl = 12'h800;
        end
    end

    assign bus.PID_cntrl = w_pid_cntrl;

    // Soft-start timer next state: cleared while unpowered, stops at 0xFF.
    always_comb begin
        long_tmr_d = long_tmr_q;
        if (!bus.pwr_up) begin
            long_tmr_d = '0;
        end else if (long_tmr_q[26:19] != 8'hFF) begin
            long_tmr_d = long_tmr_q + c_tmr_inc;
        end
    end

    // Soft-start timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_tmr_q <= '0;
        end else begin
            long_tmr_q <= long_tmr_d;
        end
    end

    assign bus.ss_tmr = long_tmr_q[26:19];

endmodule
`default_nettype wire

// File: tb/tb_pid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pid
//  Description : Self-checking bench for pid: table of combinational P+D
//                vectors, then directed integration, clear, saturation,
//                reset and soft-start sequences (FAST_SIM timer).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pid;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    pid_if u_if ();

    pid #(
        .P_COEFF  (5'h09),
        .FAST_SIM (1'b1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ptch;
        logic [15:0] ptch_rt;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;

        // P+D only (integrator held at zero by rider_off).
        vecs[0]  = '{16'h0000, 16'h0000, 12'h000};
        vecs[1]  = '{16'h0002, 16'h0000, 12'h012};
        vecs[2]  = '{16'h7FFF, 16'h0000, 12'h7FF};
        vecs[3]  = '{16'h8000, 16'h0000, 12'h800};
        vecs[4]  = '{16'h0400, 16'h0000, 12'h7FF};
        vecs[5]  = '{16'hFC00, 16'h0000, 12'h800};
        vecs[6]  = '{16'h0000, 16'h0100, 12'hFFC};
        vecs[7]  = '{16'h0000, 16'h7FFF, 12'hE01};
        vecs[8]  = '{16'h0000, 16'h8000, 12'h200};
        vecs[9]  = '{16'h0000, 16'hFFC0, 12'h001};
        vecs[10] = '{16'h0000, 16'hFFFF, 12'h001};
        vecs[11] = '{16'h00E3, 16'h0000, 12'h7FB};
        vecs[12] = '{16'h00E4, 16'h0000, 12'h7FF};
        vecs[13] = '{16'hFF1D, 16'h0000, 12'h805};
        vecs[14] = '{16'hFF1C, 16'h0000, 12'h800};
        vecs[15] = '{16'h0064, 16'h0140, 12'h37F};
        vecs[16] = '{16'h01FF, 16'h7FFF, 12'h7FF};
        vecs[17] = '{16'hFE00, 16'h8000, 12'h800};
        vecs[18] = '{16'h0038, 16'hFFC0, 12'h1F9};
        vecs[19] = '{16'hFFC8, 16'h0200, 12'hE00};

        // Reset with all data inputs zero, vld and rider_off high.
        rst_n           = 1'b0;
        u_if.vld        = 1'b1;
        u_if.rider_off  = 1'b1;
        u_if.pwr_up     = 1'b0;
        u_if.ptch       = 16'h0000;
        u_if.ptch_rt    = 16'h0000;
        #1;
        chk("reset_pid", u_if.PID_cntrl, 12'h000);
        chk("reset_ss", {4'h0, u_if.ss_tmr}, 12'h000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        chk("post_reset_pid", u_if.PID_cntrl, 12'h000);

        for (int i = 0; i < 20; i++) begin
            u_if.ptch    = vecs[i].ptch;
            u_if.ptch_rt = vecs[i].ptch_rt;
            #1;
            chk($sformatf("vec%0d", i), u_if.PID_cntrl, vecs[i].exp);
            step(1);
        end

        // Zero in, then ptch=2 visible in the same cycle.
        u_if.ptch    = 16'h0000;
        u_if.ptch_rt = 16'h0000;
        #1;
        chk("zero_in", u_if.PID_cntrl, 12'h000);
        u_if.ptch = 16'h0002;
        #1;
        chk("p_only_2", u_if.PID_cntrl, 12'h012);

        // Timer idle while unpowered (would have advanced by now if enabled).
        step(3000);
        chk("ss_idle", {4'h0, u_if.ss_tmr}, 12'h000);
        u_if.pwr_up  = 1'b1;
        u_if.ptch_rt = 16'h0100;
        #1;
        chk("p_plus_d", u_if.PID_cntrl, 12'h00E);

        // Integration: I lags the sample by one edge.
        u_if.ptch      = 16'h007F;
        u_if.rider_off = 1'b0;
        u_if.vld       = 1'b1;
        #1;
        chk("integ_pre_edge", u_if.PID_cntrl, 12'h473);
        step(1);
        chk("integ_1", u_if.PID_cntrl, 12'h474);
        step(2);
        chk("integ_3", u_if.PID_cntrl, 12'h478);
        u_if.ptch = 16'h00FF;
        #1;
        chk("pos_sat", u_if.PID_cntrl, 12'h7FF);

        // Drive the integrator into the positive overflow guard.
        u_if.ptch = 16'h003F;
        step(2400);
        u_if.ptch = 16'h0000;
        #1;
        chk("integ_park_pos", u_if.PID_cntrl, 12'h7FB);
        step(5);
        chk("integ_park_hold", u_if.PID_cntrl, 12'h7FB);

        // rider_off clears the integrator on the next edge.
        u_if.ptch      = 16'h0010;
        u_if.rider_off = 1'b1;
        step(1);
        chk("rider_off_clr", u_if.PID_cntrl, 12'h08C);

        // vld-gated integration: 3 updates in 6 edges.
        u_if.rider_off = 1'b0;
        u_if.ptch      = 16'hFF80;
        u_if.ptch_rt   = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            u_if.vld = (i % 2 == 0);
            step(1);
        end
        chk("vld_gated", u_if.PID_cntrl, 12'hB7A);
        u_if.ptch = 16'hFF00;
        #1;
        chk("neg_sat", u_if.PID_cntrl, 12'h800);

        // Drive the integrator into the negative overflow guard (-131072).
        u_if.ptch = 16'hFF80;
        u_if.vld  = 1'b1;
        step(2400);
        u_if.ptch = 16'h0040;
        #1;
        chk("integ_park_neg", u_if.PID_cntrl, 12'hA40);

        // Asynchronous reset mid-cycle clears integrator and timer at once.
        u_if.vld = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pid", u_if.PID_cntrl, 12'h240);
        chk("async_rst_ss", {4'h0, u_if.ss_tmr}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Soft-start with 256/cycle: one ss_tmr step per 2048 edges.
        step(2047);
        chk("ss_before_1", {4'h0, u_if.ss_tmr}, 12'h000);
        step(1);
        chk("ss_step_1", {4'h0, u_if.ss_tmr}, 12'h001);
        step(2048);
        chk("ss_step_2", {4'h0, u_if.ss_tmr}, 12'h002);
        u_if.pwr_up = 1'b0;
        step(1);
        chk("ss_pwr_clr", {4'h0, u_if.ss_tmr}, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
